// File: rtl/pe_cube_pkg.sv
// Shared definitions for the pe_cube result path: lane/word geometry,
// writeback FSM states and a lane byte extraction helper.
package pe_cube_pkg;

  localparam int ARRAY_NUM_DEF = 3;
  localparam int BLOCK_NUM_DEF = 3;
  localparam int CUBE_NUM_DEF  = 3;
  localparam int LANES         = ARRAY_NUM_DEF * BLOCK_NUM_DEF * CUBE_NUM_DEF;
  localparam int WORDS         = (LANES + 3) / 4;

  // Widest lane vector lane_byte accepts; callers zero-extend into it.
  localparam int MAX_LANES     = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    PEND    = 2'd3
  } wb_state_e;

  function automatic logic [7:0] lane_byte(input logic [8*MAX_LANES-1:0] vec, input int i);
    return vec[8*i +: 8];
  endfunction

endpackage

// File: rtl/result_capture_bank.sv
// Per-lane capture bank: one byte and one flag per lane, with full and
// overflow detection that already accounts for lanes captured on this edge.
module result_capture_bank
  import pe_cube_pkg::*;
#(
  parameter int LANES_N = LANES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 capture_en,
  input  logic                 clear,
  input  logic [8*LANES_N-1:0] result,
  input  logic [LANES_N-1:0]   valid,
  output logic [8*LANES_N-1:0] bytes_next,
  output logic                 full,
  output logic                 overflow
);

  logic [LANES_N-1:0]     flag_reg;
  logic [8*LANES_N-1:0]   byte_reg;
  logic [LANES_N-1:0]     take;
  logic [8*MAX_LANES-1:0] result_ext;

  assign result_ext = (8*MAX_LANES)'(result);

  generate
    for (genvar gi = 0; gi < LANES_N; gi++) begin : g_lane
      assign take[gi] = capture_en & valid[gi] & ~flag_reg[gi];
      assign bytes_next[8*gi +: 8] = take[gi] ? lane_byte(result_ext, gi) : byte_reg[8*gi +: 8];
    end
  endgenerate

  assign full     = &(flag_reg | take);
  assign overflow = |(valid & flag_reg) & capture_en;

  // Bytes of unflagged lanes are never consumed, so they may update freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_reg <= '0;
      byte_reg <= '0;
    end else begin
      byte_reg <= bytes_next;
      if (clear) flag_reg <= '0;
      else       flag_reg <= flag_reg | take;
    end
  end

endmodule

// File: rtl/result_writeback.sv
// Tile writeback: captures lane results, ping-pongs full tiles into a shadow
// and drains them as 32-bit RAM words. RESULT_WB_RELU_EN clamps negative bytes.
module result_writeback
  import pe_cube_pkg::*;
#(
  parameter int ARRAY_NUM  = ARRAY_NUM_DEF,
  parameter int BLOCK_NUM  = BLOCK_NUM_DEF,
  parameter int CUBE_NUM   = CUBE_NUM_DEF,
  parameter int RAM_DEPTH  = 2048,
  localparam int AW        = $clog2(RAM_DEPTH),
  localparam int NLANES    = ARRAY_NUM * BLOCK_NUM * CUBE_NUM
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iStart,
  input  logic [AW-1:0]       iBaseAddr,
  input  logic [15:0]         iNumTiles,
  input  logic [8*NLANES-1:0] iResult,
  input  logic [NLANES-1:0]   iResultValid,
  output logic                oWriteEn,
  output logic [AW-1:0]       oAddr,
  output logic [31:0]         oData,
  output logic                oBusy,
  output logic                oTileDone,
  output logic                oDone,
  output logic                oOverflow
);

  localparam int NWORDS = (NLANES + 3) / 4;
  localparam int WIW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [AW-1:0]  ADDR_LAST = AW'(RAM_DEPTH - 1);
  localparam logic [WIW-1:0] WORD_LAST = WIW'(NWORDS - 1);

  wb_state_e             state_reg, state_next;
  logic [8*NLANES-1:0]   shadow_reg;
  logic [8*NLANES-1:0]   shadow_in;
  logic [32*NWORDS-1:0]  shadow_pad;
  logic [31:0]           words [NWORDS];
  logic [WIW-1:0]        word_idx_reg;
  logic [AW-1:0]         addr_ptr_reg, addr_ptr_inc;
  logic [15:0]           tiles_reg;
  logic                  overflow_reg;

  logic [8*NLANES-1:0]   bank_bytes_next;
  logic                  bank_full, bank_overflow;

  logic start_accept, draining, last_word, final_word, load_shadow;

  logic          write_en_reg, write_en_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [31:0]   data_reg, data_next;
  logic          tile_done_reg, tile_done_next;
  logic          done_reg, done_next;
  logic          busy_reg, busy_next;

  assign start_accept = (state_reg == IDLE) && iStart;
  assign draining     = (state_reg == DRAIN) || (state_reg == PEND);
  assign last_word    = draining && (word_idx_reg == WORD_LAST);
  assign final_word   = last_word && (tiles_reg == 16'd1);
  assign addr_ptr_inc = (addr_ptr_reg == ADDR_LAST) ? '0 : addr_ptr_reg + 1'b1;

  result_capture_bank #(
    .LANES_N (NLANES)
  ) u_bank (
    .clk        (iClk),
    .rst        (iRst),
    .capture_en (state_reg != IDLE),
    .clear      (start_accept | load_shadow),
    .result     (iResult),
    .valid      (iResultValid),
    .bytes_next (bank_bytes_next),
    .full       (bank_full),
    .overflow   (bank_overflow)
  );

  generate
    for (genvar gi = 0; gi < NLANES; gi++) begin : g_clamp
`ifdef RESULT_WB_RELU_EN
      assign shadow_in[8*gi +: 8] = bank_bytes_next[8*gi+7] ? 8'h00 : bank_bytes_next[8*gi +: 8];
`else
      assign shadow_in[8*gi +: 8] = bank_bytes_next[8*gi +: 8];
`endif
    end
  endgenerate

  // Lanes beyond NLANES in the last word come out as zero padding.
  assign shadow_pad = (32*NWORDS)'(shadow_reg);

  generate
    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
      assign words[gi] = shadow_pad[32*gi +: 32];
    end
  endgenerate

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // A bank filling on the shadow's last word goes straight to the shadow.
  always_comb begin
    state_next  = state_reg;
    load_shadow = 1'b0;
    case (state_reg)
      IDLE: begin
        if (iStart) state_next = COLLECT;
      end
      COLLECT: begin
        if (bank_full) begin
          state_next  = DRAIN;
          load_shadow = 1'b1;
        end
      end
      DRAIN: begin
        if (last_word) begin
          if (final_word) begin
            state_next = IDLE;
          end else if (bank_full) begin
            state_next  = DRAIN;
            load_shadow = 1'b1;
          end else begin
            state_next = COLLECT;
          end
        end else if (bank_full) begin
          state_next = PEND;
        end
      end
      PEND: begin
        if (last_word) begin
          if (final_word) begin
            state_next = IDLE;
          end else begin
            state_next  = DRAIN;
            load_shadow = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    write_en_next  = draining;
    addr_next      = draining ? addr_ptr_reg : '0;
    data_next      = draining ? words[word_idx_reg] : '0;
    tile_done_next = last_word;
    done_next      = final_word;
    busy_next      = (state_next != IDLE);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      shadow_reg   <= '0;
      word_idx_reg <= '0;
      addr_ptr_reg <= '0;
      tiles_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (start_accept) begin
        addr_ptr_reg <= iBaseAddr;
        tiles_reg    <= (iNumTiles == 16'd0) ? 16'd1 : iNumTiles;
        overflow_reg <= 1'b0;
      end else begin
        if (bank_overflow) overflow_reg <= 1'b1;
        if (draining)      addr_ptr_reg <= addr_ptr_inc;
        if (last_word)     tiles_reg    <= tiles_reg - 16'd1;
      end
      if (load_shadow) begin
        shadow_reg   <= shadow_in;
        word_idx_reg <= '0;
      end else if (last_word) begin
        word_idx_reg <= '0;
      end else if (draining) begin
        word_idx_reg <= word_idx_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      write_en_reg  <= 1'b0;
      addr_reg      <= '0;
      data_reg      <= '0;
      tile_done_reg <= 1'b0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      write_en_reg  <= write_en_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      tile_done_reg <= tile_done_next;
      done_reg      <= done_next;
      busy_reg      <= busy_next;
    end
  end

  assign oWriteEn  = write_en_reg;
  assign oAddr     = addr_reg;
  assign oData     = data_reg;
  assign oTileDone = tile_done_reg;
  assign oDone     = done_reg;
  assign oBusy     = busy_reg;
  assign oOverflow = overflow_reg;

endmodule
